fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter IMEM_ADDR_BITS, default 10: byte-address span of instruction memory, 256 words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 imem_addr  output  32  byte address driven to instruction memory; equals current PC, combinational from PC register.
REQ-006 imem_rdata  input  32  instruction word returned combinationally for imem_addr in the same cycle.
REQ-007 stall  input  1  decode/hazard request to insert a bubble and hold the PC.
REQ-008 redirect_valid  input  1  branch/jump taken; overrides stall and handshake.
REQ-009 redirect_target  input  32  new PC byte address accompanying redirect_valid.
REQ-010 out_valid  output  1  IF/ID register holds a valid instruction.
REQ-011 out_ready  input  1  downstream accepts the IF/ID contents this cycle.
REQ-012 out_instr  output  32  registered instruction word.
REQ-013 out_pc  output  32  registered PC of out_instr.
REQ-014 out_pc_plus4  output  32  out_pc + 4, modulo 2^32.
REQ-015 out_fault  output  1  registered: out_pc lay outside instruction memory span.
REQ-016 fetch_count  output  32  number of instructions loaded into IF/ID since reset.

Function
REQ-017 advance = !out_valid || out_ready; the IF/ID register is written only when advance is 1 or redirect_valid is 1.
REQ-018 Priority per cycle: redirect_valid, then !advance (hold), then stall, then normal fetch.
REQ-019 Redirect: PC <= {redirect_target[31:2], 2'b00}; out_valid <= 0; other IF/ID fields hold; fetch_count holds.
REQ-020 Hold (!advance, no redirect): PC and all IF/ID outputs and fetch_count keep their values.
REQ-021 Stall (advance, no redirect): PC holds; out_valid <= 0 (bubble); other IF/ID fields hold.
REQ-022 Normal fetch: out_instr <= imem_rdata, out_pc <= PC, out_pc_plus4 <= PC + 4, out_valid <= 1, PC <= PC + 4, fetch_count <= fetch_count + 1.
REQ-023 Out-of-range fetch: PC[31:IMEM_ADDR_BITS] != 0 at a normal fetch -> out_fault <= 1, out_instr <= NOP (32'h0000_0000), out_valid <= 1; otherwise out_fault <= 0.
REQ-024 PC increment wraps: 32'hFFFF_FFFC + 4 -> 32'h0000_0000; fetch_count wraps 2^32-1 -> 0.
REQ-025 Latency: instruction at PC appears on out_instr the cycle after it is addressed; one instruction per cycle sustained with out_ready=1, stall=0.
REQ-026 Redirect in the same cycle as out_valid=1, out_ready=0: the held instruction is discarded (out_valid <= 0).
REQ-027 PC bits [1:0] are always 0.

Reset
REQ-028 On rst=1 at a rising edge: PC <= {RESET_PC[31:2],2'b00}, out_valid <= 0, out_instr <= 0, out_pc <= 0, out_pc_plus4 <= 0, out_fault <= 0, fetch_count <= 0.
REQ-029 rst dominates redirect_valid, stall and out_ready; the first fetch occurs on the first edge after rst deasserts.

Structure
REQ-030 Shared package fetch_pkg holds NOP_INSTR, default RESET_PC and IMEM_ADDR_BITS.
REQ-031 One sub-module pc_reg (PC register with load/increment/hold) is instantiated; the IF/ID register lives in fetch_stage.

Verification
REQ-032 Reset, then 4 cycles out_ready=1, memory word[i]=0x1000_0000+i -> out_pc 0,4,8,12; out_instr 0x1000_0000..0x1000_0003; fetch_count=4.
REQ-033 stall=1 for 2 cycles at PC=8 -> out_valid 0 for 2 cycles, imem_addr stays 8, then out_pc=8 resumes.
REQ-034 out_valid=1, out_ready=0 for 3 cycles -> out_instr/out_pc/fetch_count unchanged, imem_addr unchanged.
REQ-035 redirect_valid=1, target=0x0000_0043, with out_ready=0 and stall=1 -> next cycle out_valid=0, imem_addr=0x40; following cycle out_pc=0x40.
REQ-036 redirect target 0x0000_0400 -> out_fault=1, out_instr=0, out_valid=1; redirect 0xFFFF_FFFC then fetch -> out_pc_plus4=0, imem_addr=0.
REQ-037 rst asserted mid-stream at PC=0x20 with redirect_valid=1 -> all outputs reset values, imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch stage: default reset PC,
// instruction memory span and the bubble/fault instruction encoding.
package fetch_pkg;

  localparam logic [31:0]   NOP_INSTR              = 32'h0000_0000;
  localparam logic [31:0]   DEFAULT_RESET_PC       = 32'h0000_0000;
  localparam int unsigned   DEFAULT_IMEM_ADDR_BITS = 10;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: synchronous reset, word-aligned load, +4 increment, else hold.
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [29:0] i_load_word,
  input  logic        i_inc,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;

  // Load wins over increment; both paths keep bits [1:0] at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= {RESET_PC[31:2], 2'b00};
    end else if (i_load) begin
      r_pc <= {i_load_word, 2'b00};
    end else if (i_inc) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the PC to instruction memory and captures the
// returned word into the IF/ID register with stall, back-pressure and redirect handling.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_ADDR_BITS = DEFAULT_IMEM_ADDR_BITS
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        out_fault,
  output logic [31:0] fetch_count
);

  logic [31:0] w_pc;
  logic        w_advance;
  logic        w_fetch;
  logic        w_out_of_range;

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_pc_plus4;
  logic        r_fault;
  logic [31:0] r_count;

  assign w_advance = !r_valid || out_ready;
  assign w_fetch   = !redirect_valid && w_advance && !stall;

  // Any PC bit at or above the memory span marks the fetch as faulting.
  assign w_out_of_range = (IMEM_ADDR_BITS < 32) ? ((w_pc >> IMEM_ADDR_BITS) != 32'd0) : 1'b0;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .i_load      (redirect_valid),
    .i_load_word (redirect_target[31:2]),
    .i_inc       (w_fetch),
    .o_pc        (w_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_instr    <= 32'd0;
      r_pc       <= 32'd0;
      r_pc_plus4 <= 32'd0;
      r_fault    <= 1'b0;
      r_count    <= 32'd0;
    end else if (redirect_valid) begin
      // Squash whatever is held, even if downstream has not accepted it.
      r_valid <= 1'b0;
    end else if (w_advance) begin
      if (stall) begin
        r_valid <= 1'b0;
      end else begin
        r_valid    <= 1'b1;
        r_instr    <= w_out_of_range ? NOP_INSTR : imem_rdata;
        r_pc       <= w_pc;
        r_pc_plus4 <= w_pc + 32'd4;
        r_fault    <= w_out_of_range;
        r_count    <= r_count + 32'd1;
      end
    end
  end

  assign imem_addr    = w_pc;
  assign out_valid    = r_valid;
  assign out_instr    = r_instr;
  assign out_pc       = r_pc;
  assign out_pc_plus4 = r_pc_plus4;
  assign out_fault    = r_fault;
  assign fetch_count  = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic
// compared each cycle against a behavioural model of the fetch rules.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        out_fault;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];

  // Model state
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_opc;
  logic [31:0] m_p4;
  logic        m_fault;
  logic [31:0] m_count;

  always #5 clk = ~clk;

  assign imem_rdata = (imem_addr < 32'd1024) ? mem[imem_addr[9:2]] : 32'hDEAD_BEEF;

  wire [161:0] w_obs = {imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, out_fault,
                        fetch_count};
  wire [161:0] w_exp = {m_pc, m_valid, m_instr, m_opc, m_p4, m_fault, m_count};

  fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_pc_plus4    (out_pc_plus4),
    .out_fault       (out_fault),
    .fetch_count     (fetch_count)
  );

  task automatic drive(input logic r, input logic s, input logic rv, input logic [31:0] tgt,
                       input logic rdy);
    rst             = r;
    stall           = s;
    redirect_valid  = rv;
    redirect_target = tgt;
    out_ready       = rdy;
  endtask

  // Apply the fetch rules to the model for the inputs present at the coming edge.
  task automatic model_step();
    if (rst) begin
      m_pc = 32'h0; m_valid = 1'b0; m_instr = '0; m_opc = '0; m_p4 = '0;
      m_fault = 1'b0; m_count = '0;
    end else if (redirect_valid) begin
      m_pc    = redirect_target & 32'hFFFF_FFFC;
      m_valid = 1'b0;
    end else if (!m_valid || out_ready) begin
      if (stall) begin
        m_valid = 1'b0;
      end else begin
        if (m_pc >= 32'd1024) begin
          m_instr = 32'h0; m_fault = 1'b1;
        end else begin
          m_instr = mem[m_pc / 4]; m_fault = 1'b0;
        end
        m_opc   = m_pc;
        m_p4    = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
        m_count = m_count + 32'd1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'($urandom), 1'b1, $urandom, 1'($urandom));
    tick();
    tick();
    checks++;
    if (w_obs !== w_exp) begin
      errors++;
      $display("FAIL reset_model: got %h want %h", w_obs, w_exp);
    end
    checks++;
    if ({imem_addr, out_valid, out_instr, out_pc, out_fault, fetch_count} !== 130'd0) begin
      errors++;
      $display("FAIL reset_values: got addr=%h v=%b pc=%h cnt=%h", imem_addr, out_valid,
               out_pc, fetch_count);
    end
  endtask

  task automatic test_stream();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (w_obs !== w_exp) begin
        errors++;
        $display("FAIL stream_model[%0d]: got %h want %h", i, w_obs, w_exp);
      end
      checks++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i)}) begin
        errors++;
        $display("FAIL stream[%0d]: got v=%b pc=%h instr=%h want pc=%h instr=%h", i, out_valid,
                 out_pc, out_instr, i * 4, 32'h1000_0000 + 32'(i));
      end
    end
    checks++;
    if (fetch_count !== 32'd4) begin
      errors++;
      $display("FAIL stream_count: got %0d want 4", fetch_count);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (w_obs !== w_exp || out_valid !== 1'b0 || imem_addr !== 32'h8) begin
        errors++;
        $display("FAIL stall[%0d]: got v=%b addr=%h want v=0 addr=8", i, out_valid, imem_addr);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    checks++;
    if (w_obs !== w_exp || out_valid !== 1'b1 || out_pc !== 32'h8) begin
      errors++;
      $display("FAIL stall_resume: got v=%b pc=%h want v=1 pc=8", out_valid, out_pc);
    end
  endtask

  // Entered with out_pc=8 valid, fetch_count=3, PC=12.
  task automatic test_hold();
    drive(1'b0, 1'($urandom), 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (w_obs !== w_exp ||
          {out_valid, out_instr, out_pc, fetch_count, imem_addr} !==
          {1'b1, 32'h1000_0002, 32'h8, 32'd3, 32'hC}) begin
        errors++;
        $display("FAIL hold[%0d]: got v=%b instr=%h pc=%h cnt=%0d addr=%h", i, out_valid,
                 out_instr, out_pc, fetch_count, imem_addr);
      end
    end
  endtask

  task automatic test_redirect();
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0043, 1'b0);
    tick();
    checks++;
    if (w_obs !== w_exp || out_valid !== 1'b0 || imem_addr !== 32'h40 || out_pc !== 32'h8) begin
      errors++;
      $display("FAIL redirect: got v=%b addr=%h pc=%h want v=0 addr=40 pc=8", out_valid,
               imem_addr, out_pc);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    checks++;
    if (w_obs !== w_exp || out_pc !== 32'h40 || out_instr !== 32'h1000_0010 ||
        fetch_count !== 32'd4) begin
      errors++;
      $display("FAIL redirect_fetch: got pc=%h instr=%h cnt=%0d want pc=40 instr=10000010 cnt=4",
               out_pc, out_instr, fetch_count);
    end
  endtask

  task automatic test_fault();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0400, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    checks++;
    if (w_obs !== w_exp || {out_fault, out_instr, out_valid, out_pc} !==
        {1'b1, 32'h0, 1'b1, 32'h400}) begin
      errors++;
      $display("FAIL fault: got f=%b instr=%h v=%b pc=%h want f=1 instr=0 v=1 pc=400",
               out_fault, out_instr, out_valid, out_pc);
    end
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    checks++;
    if (w_obs !== w_exp || {out_pc, out_pc_plus4, imem_addr, out_fault} !==
        {32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL wrap: got pc=%h p4=%h addr=%h f=%b want pc=fffffffc p4=0 addr=0 f=1",
               out_pc, out_pc_plus4, imem_addr, out_fault);
    end
    tick();
    checks++;
    if (w_obs !== w_exp || {out_pc, out_fault, out_instr} !== {32'h0, 1'b0, 32'h1000_0000}) begin
      errors++;
      $display("FAIL wrap_next: got pc=%h f=%b instr=%h want pc=0 f=0 instr=10000000",
               out_pc, out_fault, out_instr);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0020, 1'b1);
    tick();
    checks++;
    if (imem_addr !== 32'h20) begin
      errors++;
      $display("FAIL reset_mid_setup: got addr=%h want 20", imem_addr);
    end
    drive(1'b1, 1'($urandom), 1'b1, 32'h0000_0080, 1'($urandom));
    tick();
    checks++;
    if (w_obs !== w_exp || w_obs !== 162'd0) begin
      errors++;
      $display("FAIL reset_mid: got %h want all zero", w_obs);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    checks++;
    if (w_obs !== w_exp || {out_valid, out_pc, fetch_count} !== {1'b1, 32'h0, 32'd1}) begin
      errors++;
      $display("FAIL reset_first_fetch: got v=%b pc=%h cnt=%0d want v=1 pc=0 cnt=1",
               out_valid, out_pc, fetch_count);
    end
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else                           tgt = 32'($urandom_range(0, 1200));
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), tgt, ($urandom_range(0, 2) != 0));
      tick();
      checks++;
      if (w_obs !== w_exp) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h", i, w_obs, w_exp);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    test_reset();
    test_stream();
    test_stall();
    test_hold();
    test_redirect();
    test_fault();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
